// File: rtl/spi_arbiter_seq_pkg.sv
// Shared definitions for the SPI master arbiter/sequencer: state encoding,
// mode bit positions and default bus widths.
package spi_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_ARM  = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    ARM  = ST_ARM,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Bit positions inside a requester's 2-bit {CPOL,CPHA} mode field
  localparam int MODE_CPOL = 1;
  localparam int MODE_CPHA = 0;

  localparam int DEF_C = 32;
  localparam int DEF_N = 1;

  // Round-robin pointer width; a single requester still gets one bit
  function automatic int ptr_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/spi_arbiter_seq_if.sv
// Requester-side and SPI-master-side signals of the arbiter. The master
// modport is the arbiter's view; the slave modport is its environment.
interface spi_arbiter_seq_if
  import spi_pkg::*;
#(
  parameter int R = 2,
  parameter int N = DEF_N,
  parameter int C = DEF_C
);

  logic [R-1:0]   req;
  logic [R*C-1:0] req_din;
  logic [R*N-1:0] req_target;
  logic [2*R-1:0] req_mode;
  logic [R-1:0]   gnt;
  logic [R-1:0]   rsp_valid;
  logic [C-1:0]   rsp_dout;
  logic           rsp_err;
  logic           busy;

  logic [C-1:0]   spi_din;
  logic [N-1:0]   spi_target;
  logic           spi_cpol;
  logic           spi_cpha;
  logic           spi_trigger;
  logic [C-1:0]   spi_dout;
  logic           spi_valid;

  modport master (
    input  req, req_din, req_target, req_mode, spi_dout, spi_valid,
    output gnt, rsp_valid, rsp_dout, rsp_err, busy,
           spi_din, spi_target, spi_cpol, spi_cpha, spi_trigger
  );

  modport slave (
    output req, req_din, req_target, req_mode, spi_dout, spi_valid,
    input  gnt, rsp_valid, rsp_dout, rsp_err, busy,
           spi_din, spi_target, spi_cpol, spi_cpha, spi_trigger
  );

endinterface

// File: rtl/spi_arbiter_seq_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr,
// wrapping, returned both one-hot and encoded.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int R  = 2,
  parameter int PW = ptr_width(R)
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [R-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          hit
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    hit  = 1'b0;
    cand = 0;
    for (int k = 0; k < R; k++) begin
      cand = (int'(ptr) + k) % R;
      if (!hit && req[cand]) begin
        hit       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter_seq.sv
// Shares one SPI master between R requesters: round-robin grant, one
// trigger per grant, completion via the master's valid flag, with timeout.
module spi_arbiter_seq
  import spi_pkg::*;
#(
  parameter int R  = 2,
  parameter int N  = DEF_N,
  parameter int C  = DEF_C,
  parameter int TO = 1024
) (
  input logic                CLK_IN,
  input logic                RST,
  spi_arbiter_seq_if.master  bus
);

  localparam int PW = ptr_width(R);
  localparam int TW = $clog2(TO) + 1;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [TW-1:0]   timer_reg;
  logic [R-1:0]    win_reg;
  logic [R-1:0]    gnt_reg;
  logic [R-1:0]    rsp_valid_reg;
  logic [C-1:0]    rsp_dout_reg;
  logic            rsp_err_reg;
  logic            busy_reg;
  logic [C-1:0]    spi_din_reg;
  logic [N-1:0]    spi_target_reg;
  logic            spi_cpol_reg;
  logic            spi_cpha_reg;
  logic            spi_trigger_reg;

  logic [C-1:0]    din_arr  [R];
  logic [N-1:0]    tgt_arr  [R];
  logic [1:0]      mode_arr [R];

  logic [R-1:0]    arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_hit;
  logic            timeout;

  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_slice
      assign din_arr[gi]  = bus.req_din[gi*C +: C];
      assign tgt_arr[gi]  = bus.req_target[gi*N +: N];
      assign mode_arr[gi] = bus.req_mode[2*gi +: 2];
    end
  endgenerate

  rr_arbiter #(.R(R), .PW(PW)) u_arb (
    .req (bus.req),
    .ptr (ptr_reg),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .hit (arb_hit)
  );

  assign timeout = (timer_reg == TW'(TO - 1));

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      timer_reg       <= '0;
      win_reg         <= '0;
      gnt_reg         <= '0;
      rsp_valid_reg   <= '0;
      rsp_dout_reg    <= '0;
      rsp_err_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      spi_din_reg     <= '0;
      spi_target_reg  <= '0;
      spi_cpol_reg    <= 1'b0;
      spi_cpha_reg    <= 1'b0;
      spi_trigger_reg <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless a state re-asserts them
      gnt_reg         <= '0;
      rsp_valid_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      spi_trigger_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (arb_hit) begin
            gnt_reg         <= arb_gnt;
            win_reg         <= arb_gnt;
            busy_reg        <= 1'b1;
            spi_din_reg     <= din_arr[arb_idx];
            spi_target_reg  <= tgt_arr[arb_idx];
            spi_cpol_reg    <= mode_arr[arb_idx][MODE_CPOL];
            spi_cpha_reg    <= mode_arr[arb_idx][MODE_CPHA];
            spi_trigger_reg <= 1'b1;
            ptr_reg         <= (arb_idx == PW'(R - 1)) ? '0 : arb_idx + 1'b1;
            state_reg       <= LOAD;
          end
        end

        LOAD: begin
          timer_reg <= '0;
          state_reg <= ARM;
        end

        // Master drops valid when it captures the trigger; a stale high
        // valid from the previous transfer must not count as completion.
        ARM: begin
          timer_reg <= timer_reg + 1'b1;
          if (timeout) begin
            rsp_valid_reg <= win_reg;
            rsp_err_reg   <= 1'b1;
            rsp_dout_reg  <= bus.spi_dout;
            state_reg     <= DONE;
          end else if (!bus.spi_valid) begin
            state_reg <= RUN;
          end
        end

        RUN: begin
          timer_reg <= timer_reg + 1'b1;
          if (bus.spi_valid) begin
            rsp_valid_reg <= win_reg;
            rsp_dout_reg  <= bus.spi_dout;
            state_reg     <= DONE;
          end else if (timeout) begin
            rsp_valid_reg <= win_reg;
            rsp_err_reg   <= 1'b1;
            rsp_dout_reg  <= bus.spi_dout;
            state_reg     <= DONE;
          end
        end

        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_dout    = rsp_dout_reg;
  assign bus.rsp_err     = rsp_err_reg;
  assign bus.busy        = busy_reg;
  assign bus.spi_din     = spi_din_reg;
  assign bus.spi_target  = spi_target_reg;
  assign bus.spi_cpol    = spi_cpol_reg;
  assign bus.spi_cpha    = spi_cpha_reg;
  assign bus.spi_trigger = spi_trigger_reg;

endmodule

// File: tb/tb_spi_arbiter_seq.sv
// Scoreboard bench for spi_arbiter_seq with a behavioural SPI master that
// drops valid on trigger and raises it DLY cycles later (or never).
module tb_spi_arbiter_seq;
  import spi_pkg::*;

  localparam int R   = 2;
  localparam int N   = 1;
  localparam int C   = 32;
  localparam int TO  = 200;
  localparam int DLY = 70;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_arbiter_seq_if #(.R(R), .N(N), .C(C)) bus ();

  spi_arbiter_seq #(.R(R), .N(N), .C(C), .TO(TO)) dut (
    .CLK_IN (clk),
    .RST    (rst),
    .bus    (bus)
  );

  typedef struct {
    int           idx;
    logic [C-1:0] din;
    logic [1:0]   mode;
    logic [N-1:0] tgt;
    logic [C-1:0] dout;
    logic         err;
    int           lat;
  } exp_t;

  exp_t gnt_q[$];
  exp_t rsp_q[$];
  exp_t cur;
  exp_t got;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  int trig_cnt = 0;
  bit mode_bad = 1'b0;
  bit prev_busy = 1'b0;

  logic [C-1:0] din_tab  [R];
  logic [1:0]   mode_tab [R];

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [C-1:0] swap(input logic [C-1:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  function automatic void push_exp(input int idx, input logic [C-1:0] dout, input logic err, input int lat);
    exp_t e;
    e.idx  = idx;
    e.din  = din_tab[idx];
    e.mode = mode_tab[idx];
    e.tgt  = '1;
    e.dout = dout;
    e.err  = err;
    e.lat  = lat;
    gnt_q.push_back(e);
  endfunction

  // Behavioural SPI master
  logic         no_reply = 1'b0;
  logic         echo = 1'b0;
  logic [C-1:0] ret_word = 32'h1234_5678;
  logic [C-1:0] cap;
  int           cnt;
  bit           active;

  always @(posedge clk) begin
    if (rst) begin
      bus.spi_valid <= 1'b1;
      bus.spi_dout  <= 32'hBAD0_BAD0;
      active        <= 1'b0;
      cnt           <= 0;
    end else if (bus.spi_trigger) begin
      bus.spi_valid <= 1'b0;
      cap           <= bus.spi_din;
      cnt           <= DLY;
      active        <= !no_reply;
      if (no_reply) bus.spi_dout <= 32'hDEAD_0000;
    end else if (active) begin
      if (cnt <= 1) begin
        bus.spi_valid <= 1'b1;
        bus.spi_dout  <= echo ? swap(cap) : ret_word;
        active        <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Grant and response monitor
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.gnt != '0) begin
        chk_val("gnt_after_idle", 64'(prev_busy), 64'd0);
        if (gnt_q.size() == 0) begin
          chk_val("gnt_unexpected", 64'(bus.gnt), 64'd0);
        end else begin
          cur = gnt_q.pop_front();
          chk_val("gnt_onehot", 64'(bus.gnt), 64'(1) << cur.idx);
          chk_val("spi_din", 64'(bus.spi_din), 64'(cur.din));
          chk_val("spi_target", 64'(bus.spi_target), 64'(cur.tgt));
          chk_val("spi_mode", 64'({bus.spi_cpol, bus.spi_cpha}), 64'(cur.mode));
          chk_val("trig_with_gnt", 64'(bus.spi_trigger), 64'd1);
          chk_val("busy_at_gnt", 64'(bus.busy), 64'd1);
          gnt_cyc  = cyc;
          trig_cnt = 0;
          mode_bad = 1'b0;
          rsp_q.push_back(cur);
        end
      end
      if (bus.spi_trigger) trig_cnt++;
      if (bus.busy && rsp_q.size() > 0 && {bus.spi_cpol, bus.spi_cpha} !== rsp_q[0].mode)
        mode_bad = 1'b1;
      if (bus.rsp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          chk_val("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        end else begin
          got = rsp_q.pop_front();
          chk_val("rsp_onehot", 64'(bus.rsp_valid), 64'(1) << got.idx);
          chk_val("rsp_dout", 64'(bus.rsp_dout), 64'(got.dout));
          chk_val("rsp_err", 64'(bus.rsp_err), 64'(got.err));
          chk_val("busy_at_rsp", 64'(bus.busy), 64'd1);
          chk_val("trig_once", 64'(trig_cnt), 64'd1);
          chk_val("mode_stable", 64'(mode_bad), 64'd0);
          // Timeout: rsp_valid appears TO cycles after the LOAD cycle ends
          if (got.lat >= 0) chk_val("timeout_lat", 64'(cyc - gnt_cyc), 64'(got.lat));
          $display("txn req%0d dout=0x%08h err=%0d cycles=%0d", got.idx, bus.rsp_dout, bus.rsp_err, cyc - gnt_cyc);
        end
      end
    end
    prev_busy = bus.busy;
  end

  task automatic request(input int idx);
    bit seen;
    seen = 1'b0;
    bus.req[idx] = 1'b1;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      if (bus.gnt[idx]) seen = 1'b1;
    end
    bus.req[idx] = 1'b0;
    chk_val("req_granted", 64'(seen), 64'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (gnt_q.size() == 0 && rsp_q.size() == 0 && !bus.busy) done = 1'b1;
    end
    chk_val("idle_reached", 64'(done), 64'd1);
  endtask

  initial begin
    int n;
    din_tab[0]  = 32'hA5A5_0F0F;
    din_tab[1]  = 32'h3C3C_F00D;
    mode_tab[0] = 2'b10;
    mode_tab[1] = 2'b01;
    bus.req        = '0;
    bus.req_din    = {din_tab[1], din_tab[0]};
    bus.req_target = 2'b11;
    bus.req_mode   = {mode_tab[1], mode_tab[0]};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_val("rst_gnt", 64'(bus.gnt), 64'd0);
    chk_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk_val("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk_val("rst_busy", 64'(bus.busy), 64'd0);
    chk_val("rst_trigger", 64'(bus.spi_trigger), 64'd0);
    chk_val("rst_spi_din", 64'(bus.spi_din), 64'd0);
    chk_val("rst_spi_target", 64'(bus.spi_target), 64'd0);
    chk_val("rst_spi_mode", 64'({bus.spi_cpol, bus.spi_cpha}), 64'd0);
    chk_val("rst_rsp_dout", 64'(bus.rsp_dout), 64'd0);
    rst = 1'b0;

    // Single request with stale valid=1 from reset; fixed return word
    repeat (5) @(negedge clk);
    chk_val("idle_no_busy_stale_valid", 64'(bus.busy), 64'd0);
    push_exp(0, 32'h1234_5678, 1'b0, -1);
    request(0);
    wait_idle();

    // Requester 1 arrives in the middle of requester 0's transfer
    echo = 1'b1;
    push_exp(0, swap(din_tab[0]), 1'b0, -1);
    push_exp(1, swap(din_tab[1]), 1'b0, -1);
    request(0);
    repeat (20) @(negedge clk);
    request(1);
    wait_idle();

    // Contention: both held for four transfers
    for (int k = 0; k < 4; k++) push_exp(k % 2, swap(din_tab[k % 2]), 1'b0, -1);
    n = 0;
    bus.req = 2'b11;
    for (int k = 0; k < 2000 && n < 4; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) n++;
    end
    bus.req = '0;
    chk_val("contention_grants", 64'(n), 64'd4);
    wait_idle();

    // Timeout, then a normal transfer
    no_reply = 1'b1;
    push_exp(0, 32'hDEAD_0000, 1'b1, TO + 1);
    request(0);
    wait_idle();
    no_reply = 1'b0;
    push_exp(1, swap(din_tab[1]), 1'b0, -1);
    request(1);
    wait_idle();

    // Reset about 30 cycles into RUN (pointer has just moved to 1)
    push_exp(0, swap(din_tab[0]), 1'b0, -1);
    request(0);
    repeat (32) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_val("midrst_busy", 64'(bus.busy), 64'd0);
    chk_val("midrst_trigger", 64'(bus.spi_trigger), 64'd0);
    chk_val("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk_val("midrst_spi_din", 64'(bus.spi_din), 64'd0);
    rsp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Pointer back at 0: with both requesting, 0 wins first
    push_exp(0, swap(din_tab[0]), 1'b0, -1);
    push_exp(1, swap(din_tab[1]), 1'b0, -1);
    bus.req = 2'b11;
    request(0);
    request(1);
    wait_idle();

    chk_val("sb_drained", 64'(gnt_q.size() + rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
